arm_mem_port: RTL

//  Parametrised memory port for the multicycle ARM core. Replaces the zero-wait Adr/WriteData/ReadData

---
 rtl/arm_mem_pkg.sv | 24 ++
 rtl/arm_mem_watchdog.sv | 40 ++++
 rtl/arm_mem_port.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM core memory port.
//  - ST_W        : width of the port FSM state register
//  - state_e     : FSM encoding (IDLE, REQ, DONE)
//  - ST_IDLE/ST_REQ/ST_DONE : plain constants of that encoding for the FSM
//  - be_width()  : byte-enable width for a given data width
package arm_mem_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ST_W-1:0] ST_IDLE = IDLE;
  localparam logic [ST_W-1:0] ST_REQ  = REQ;
  localparam logic [ST_W-1:0] ST_DONE = DONE;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/arm_mem_watchdog.sv
// Access watchdog for arm_mem_port; only present when MEM_TIMEOUT_EN is defined.
// Counts cycles spent waiting for mem_ack and flags expiry on the TIMEOUT-th
// waiting cycle.
// Ports:
//  clk      in   rising-edge clock
//  reset    in   synchronous, active-high
//  start    in   a new access is being launched (clears the count)
//  run      in   the port is waiting for mem_ack this cycle
//  expired  out  this is the TIMEOUT-th waiting cycle (combinational)
`ifdef MEM_TIMEOUT_EN
module arm_mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);

  // One spare code so the increment on the expiry cycle never wraps silently.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt is 0 in the first waiting cycle, so TIMEOUT-1 marks the last one.
  assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/arm_mem_port.sv
// Memory port for the multicycle ARM core: turns the core's held read/write
// request into a registered req/ack transaction and stalls the core until the
// memory answers. Optional watchdog enabled by defining MEM_TIMEOUT_EN.
// Ports:
//  clk, reset              clock, synchronous active-high reset
//  core_re, core_we        core request (held until stall drops; re&we = write)
//  core_adr/wdata/be       core access address, write data, byte enables
//  core_rdata              read data, updated on completion, held otherwise
//  stall                   freezes the core while an access is outstanding
//  mem_req, mem_we         memory request and direction (1 = write)
//  mem_adr/wdata/be        registered access fields, stable during a request
//  mem_ack, mem_rdata      memory completion and read data
//  mem_err                 sticky timeout flag (0 without MEM_TIMEOUT_EN)
module arm_mem_port
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        core_re,
  input  logic                        core_we,
  input  logic [ADDR_W-1:0]           core_adr,
  input  logic [DATA_W-1:0]           core_wdata,
  input  logic [be_width(DATA_W)-1:0] core_be,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        stall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_adr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [be_width(DATA_W)-1:0] mem_be,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_err
);

  logic [ST_W-1:0] state;
  logic            req_seen;
  logic            req_start;
  logic            timeout_hit;

  assign req_seen  = core_re | core_we;
  assign req_start = (state == ST_IDLE) && req_seen;

  // The DONE cycle is the only cycle the core may advance past a request.
  assign stall = req_seen && (state != ST_DONE);

  // A TIMEOUT below 2 leaves no cycle in which an ack could beat the watchdog.
  if (TIMEOUT < 2) begin : g_timeout_unsupported
  end

`ifdef MEM_TIMEOUT_EN
  arm_mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (req_start),
    .run     (state == ST_REQ),
    .expired (timeout_hit)
  );

  // Sticky until reset; an ack in the expiry cycle still wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if ((state == ST_REQ) && !mem_ack && timeout_hit) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      // NOTE: the datapath registers are reset too, so the bus never sees X
      // address/data after reset even though mem_req qualifies them.
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      core_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_seen) begin
            mem_adr   <= core_adr;
            mem_wdata <= core_wdata;
            mem_be    <= core_be;
            mem_we    <= core_we;
            mem_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Core inputs are deliberately not sampled here: the access was
          // captured on entry and stays stable until the memory answers.
          if (mem_ack) begin
            if (!mem_we) begin
              core_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else if (timeout_hit) begin
            core_rdata <= '0;
            mem_req    <= 1'b0;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The core has advanced this cycle; any new request is sampled in IDLE.
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
